// File: rtl/router_input_port.sv
// Deframes one serial router lane (address, pad, payload) into bytes buffered in a FIFO on a valid/ready stream.
// Optional `ROUTER_IN_STATS_EN adds saturating pkt_count/err_count outputs.
module router_input_port #(
  parameter int FIFO_DEPTH  = 16,
  parameter int PAD_CYCLES  = 5,
  parameter int BUSY_THRESH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_n,
  input  logic        valid_n,
  input  logic        din,
  output logic        busy_n,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic [7:0]  pkt_data,
  output logic [3:0]  pkt_dst,
  output logic        pkt_sop,
  output logic        pkt_eop,
`ifdef ROUTER_IN_STATS_EN
  output logic [15:0] pkt_count,
  output logic [15:0] err_count,
`endif
  output logic        err_pulse
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (PAD_CYCLES < 2) ? 1 : $clog2(PAD_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_PAD, S_DATA, S_DROP} state_t;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] dst;
    logic       sop;
    logic       eop;
  } entry_t;

  state_t          state_q, state_d;
  logic [3:0]      addr_q, addr_d;
  logic [1:0]      abit_q, abit_d;
  logic [PW-1:0]   pad_q, pad_d;
  logic [7:0]      byte_q, byte_d, byte_nx;
  logic [2:0]      bcnt_q, bcnt_d;
  logic            first_q, first_d;
  logic            push_q, push_d;
  entry_t          push_ent_q, push_ent_d;
  logic            push_err_q, push_err_d;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic            fsm_err, full, pop, wr_en, ovf;
  entry_t          mem [FIFO_DEPTH];
  entry_t          head;

  // Valid/ready: an entry transfers on every rising edge where pkt_valid && pkt_ready;
  // while pkt_valid is high and pkt_ready low, the head entry is held unchanged.
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign pkt_valid = (count_q != '0);
  assign pop       = pkt_valid && pkt_ready;
  assign wr_en     = push_q && (!full || pop);
  assign ovf       = push_q && full && !pop;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    abit_d     = abit_q;
    pad_d      = pad_q;
    byte_d     = byte_q;
    bcnt_d     = bcnt_q;
    first_d    = first_q;
    push_d     = 1'b0;
    push_ent_d = push_ent_q;
    push_err_d = push_err_q;
    fsm_err    = 1'b0;
    byte_nx    = byte_q;
    byte_nx[bcnt_q] = din;
    case (state_q)
      S_IDLE: begin
        if (!frame_n) begin
          addr_d  = {3'b000, din};
          abit_d  = 2'd1;
          first_d = 1'b1;
          byte_d  = '0;
          bcnt_d  = '0;
          if (!busy_q) begin
            fsm_err = 1'b1;
            state_d = S_DROP;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (frame_n) begin
          fsm_err = 1'b1;
          state_d = S_IDLE;
        end else begin
          addr_d[abit_q] = din;
          abit_d = abit_q + 2'd1;
          if (abit_q == 2'd3) begin
            pad_d   = '0;
            state_d = (PAD_CYCLES == 0) ? S_DATA : S_PAD;
          end
        end
      end
      S_PAD: begin
        if (frame_n) begin
          fsm_err = 1'b1;
          state_d = S_IDLE;
        end else if (!valid_n) begin
          fsm_err = 1'b1;
          state_d = S_DROP;
        end else if (pad_q == PW'(PAD_CYCLES - 1)) begin
          state_d = S_DATA;
        end else begin
          pad_d = pad_q + PW'(1);
        end
      end
      S_DATA: begin
        if (!valid_n) begin
          if (frame_n || bcnt_q == 3'd7) begin
            // Byte staged here; the FIFO write happens on the following edge.
            push_d     = 1'b1;
            push_ent_d = {byte_nx, addr_q, first_q, frame_n};
            push_err_d = frame_n && (bcnt_q != 3'd7);
            first_d    = 1'b0;
            byte_d     = '0;
            bcnt_d     = '0;
            if (frame_n) begin
              fsm_err = (bcnt_q != 3'd7);
              state_d = S_IDLE;
            end
          end else begin
            byte_d = byte_nx;
            bcnt_d = bcnt_q + 3'd1;
          end
        end else if (frame_n) begin
          fsm_err = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (frame_n) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (ovf) state_d = S_DROP;
  end

  always_comb begin
    wr_d    = wr_en ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    busy_d = (FIFO_DEPTH - int'(count_d)) >= BUSY_THRESH;
    // An overflow on a byte that already flagged a partial-byte error stays a single event.
    err_d  = fsm_err || (ovf && !push_err_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      abit_q     <= '0;
      pad_q      <= '0;
      byte_q     <= '0;
      bcnt_q     <= '0;
      first_q    <= 1'b0;
      push_q     <= 1'b0;
      push_ent_q <= '0;
      push_err_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      busy_q     <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      abit_q     <= abit_d;
      pad_q      <= pad_d;
      byte_q     <= byte_d;
      bcnt_q     <= bcnt_d;
      first_q    <= first_d;
      push_q     <= push_d;
      push_ent_q <= push_ent_d;
      push_err_q <= push_err_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q] <= push_ent_q;
  end

  // Gating with pkt_valid keeps the stream fields at zero after reset and when empty.
  assign head      = mem[rd_q];
  assign pkt_data  = pkt_valid ? head.data : '0;
  assign pkt_dst   = pkt_valid ? head.dst  : '0;
  assign pkt_sop   = pkt_valid ? head.sop  : 1'b0;
  assign pkt_eop   = pkt_valid ? head.eop  : 1'b0;
  assign busy_n    = busy_q;
  assign err_pulse = err_q;

`ifdef ROUTER_IN_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (wr_en && push_ent_q.eop && pkt_cnt_q != 16'hFFFF) pkt_cnt_d = pkt_cnt_q + 16'd1;
    if (err_q && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign pkt_count = pkt_cnt_q;
  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_router_input_port.sv
// Directed bench for router_input_port: packet vector table plus hand sequences for FIFO and reset corners.
module tb_router_input_port;
  localparam int FIFO_DEPTH  = 16;
  localparam int PAD_CYCLES  = 5;
  localparam int BUSY_THRESH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_n = 1'b1;
  logic       valid_n = 1'b1;
  logic       din = 1'b0;
  logic       pkt_ready = 1'b0;
  logic       busy_n, pkt_valid, pkt_sop, pkt_eop, err_pulse;
  logic [7:0] pkt_data;
  logic [3:0] pkt_dst;
`ifdef ROUTER_IN_STATS_EN
  logic [15:0] pkt_count, err_count;
`endif

  router_input_port #(
    .FIFO_DEPTH(FIFO_DEPTH), .PAD_CYCLES(PAD_CYCLES), .BUSY_THRESH(BUSY_THRESH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_n(frame_n), .valid_n(valid_n), .din(din),
    .busy_n(busy_n), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_data(pkt_data), .pkt_dst(pkt_dst), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
`ifdef ROUTER_IN_STATS_EN
    .pkt_count(pkt_count), .err_count(err_count),
`endif
    .err_pulse(err_pulse)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout sim did not finish");
    $fatal(1);
  end

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  logic [13:0] exp_q[$];

  // One count per pulse: sampled once, 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (err_pulse === 1'b1) err_seen++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] ent(input logic [7:0] d, input logic [3:0] dst,
                                      input logic s, input logic e);
    return {d, dst, s, e};
  endfunction

  // Driver tasks: called at a falling edge, hold inputs across the next rising edge.
  task automatic drive_cycle(input logic f, input logic v, input logic d);
    frame_n = f;
    valid_n = v;
    din     = d;
    @(negedge clk);
  endtask

  task automatic drive_head(input logic [3:0] dst, input int bad_pad);
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, dst[i]);
    for (int p = 0; p < PAD_CYCLES; p++) drive_cycle(1'b0, (p == bad_pad) ? 1'b0 : 1'b1, 1'b0);
  endtask

  task automatic send_packet(input logic [3:0] dst, input int nbits, input logic [135:0] pl,
                             input int gap_at, input int bad_pad, input bit ready_on_last);
    logic [13:0] act;
    drive_head(dst, bad_pad);
    for (int b = 0; b < nbits; b++) begin
      if (b == gap_at) drive_cycle(1'b0, 1'b1, 1'b0);
      drive_cycle((b == nbits - 1), 1'b0, pl[b]);
    end
    if (ready_on_last) begin
      act = {pkt_data, pkt_dst, pkt_sop, pkt_eop};
      check("full_head", act, exp_q.pop_front());
      pkt_ready = 1'b1;
    end
    drive_cycle(1'b1, 1'b1, 1'b0);
    pkt_ready = 1'b0;
    drive_cycle(1'b1, 1'b1, 1'b0);
  endtask

  // Scoreboard: pop every available entry and compare against exp_q in order.
  task automatic drain();
    logic [13:0] act;
    for (int k = 0; k < FIFO_DEPTH + 4; k++) begin
      if (!pkt_valid) break;
      act = {pkt_data, pkt_dst, pkt_sop, pkt_eop};
      if (exp_q.size() == 0) check("unexpected_entry", act, 14'h0);
      else check("entry", act, exp_q.pop_front());
      pkt_ready = 1'b1;
      @(negedge clk);
      pkt_ready = 1'b0;
    end
    check("drain_leftover", exp_q.size(), 0);
    check("drain_empty", pkt_valid, 1'b0);
  endtask

  typedef struct {
    logic [3:0]  dst;
    int          nbits;
    logic [15:0] payload;
    int          gap_at;
    int          n_exp;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        eop0;
    int          errs;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int e0;
    logic [135:0] pl;

    vecs[0] = '{4'hA, 16, 16'h3CA5, -1, 2, 8'hA5, 8'h3C, 1'b0, 0};
    vecs[1] = '{4'h3,  3, 16'h0003, -1, 1, 8'h03, 8'h00, 1'b1, 1};
    vecs[2] = '{4'hF,  8, 16'h0081,  4, 1, 8'h81, 8'h00, 1'b1, 0};
    vecs[3] = '{4'h0,  9, 16'h01FF, -1, 2, 8'hFF, 8'h01, 1'b0, 1};
    vecs[4] = '{4'h5,  1, 16'h0001, -1, 1, 8'h01, 8'h00, 1'b1, 1};
    vecs[5] = '{4'h6, 12, 16'h0ABC,  9, 2, 8'hBC, 8'h0A, 1'b0, 1};

    repeat (2) @(negedge clk);
    check("rst_pkt_valid", pkt_valid, 1'b0);
    check("rst_busy_n", busy_n, 1'b1);
    check("rst_pkt_data", pkt_data, 8'h00);
    check("rst_pkt_dst", pkt_dst, 4'h0);
    check("rst_sop_eop", {pkt_sop, pkt_eop}, 2'b00);
    check("rst_err", err_pulse, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      e0 = err_seen;
      send_packet(vecs[v].dst, vecs[v].nbits, {120'b0, vecs[v].payload}, vecs[v].gap_at, -1, 1'b0);
      exp_q.push_back(ent(vecs[v].d0, vecs[v].dst, 1'b1, vecs[v].eop0));
      if (vecs[v].n_exp == 2) exp_q.push_back(ent(vecs[v].d1, vecs[v].dst, 1'b0, 1'b1));
      check("vec_head", {pkt_data, pkt_dst, pkt_sop, pkt_eop}, exp_q[0]);
      @(negedge clk);
      check("vec_head_hold", {pkt_data, pkt_dst, pkt_sop, pkt_eop}, exp_q[0]);
      check("vec_errs", err_seen - e0, vecs[v].errs);
      drain();
    end

    // valid_n low in pad cycle 2, then a clean packet.
    e0 = err_seen;
    send_packet(4'h2, 8, 136'h99, -1, 1, 1'b0);
    check("pad_err", err_seen - e0, 1);
    check("pad_no_entry", pkt_valid, 1'b0);
    e0 = err_seen;
    send_packet(4'hB, 8, 136'h5A, -1, -1, 1'b0);
    exp_q.push_back(ent(8'h5A, 4'hB, 1'b1, 1'b1));
    check("pad_next_errs", err_seen - e0, 0);
    drain();

    // busy_n threshold with a stalled consumer.
    for (int i = 0; i < 13; i++) begin
      send_packet(4'(i), 8, 136'(i + 'h40), -1, -1, 1'b0);
      exp_q.push_back(ent(8'(i + 'h40), 4'(i), 1'b1, 1'b1));
      if (i == 11) check("busy_after_12", busy_n, 1'b1);
    end
    check("busy_after_13", busy_n, 1'b0);
    e0 = err_seen;
    send_packet(4'h7, 8, 136'h55, -1, -1, 1'b0);
    check("busy_frame_err", err_seen - e0, 1);
    check("busy_still_low", busy_n, 1'b0);
    drain();
    check("busy_released", busy_n, 1'b1);

    // Overflow: 17-byte packet into a 16-entry FIFO with no consumer.
    pl = '0;
    for (int b = 0; b < 17; b++) begin
      pl[b*8 +: 8] = 8'(b + 'h80);
      if (b < 16) exp_q.push_back(ent(8'(b + 'h80), 4'h9, (b == 0), 1'b0));
    end
    e0 = err_seen;
    send_packet(4'h9, 136, pl, -1, -1, 1'b0);
    check("ovf_err", err_seen - e0, 1);
    check("ovf_busy", busy_n, 1'b0);
    drain();

    // Full FIFO with push and pop on the same edge.
    pl = '0;
    for (int b = 0; b < 17; b++) begin
      pl[b*8 +: 8] = 8'(b + 'h10);
      exp_q.push_back(ent(8'(b + 'h10), 4'h2, (b == 0), (b == 16)));
    end
    e0 = err_seen;
    send_packet(4'h2, 136, pl, -1, -1, 1'b1);
    check("full_pushpop_err", err_seen - e0, 0);
    check("full_busy", busy_n, 1'b0);
    check("full_valid", pkt_valid, 1'b1);
    drain();

    // Reset pulse mid-DATA with an entry already queued.
    send_packet(4'hC, 8, 136'h77, -1, -1, 1'b0);
    drive_head(4'h4, -1);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b1);
    reset_n = 1'b0;
    frame_n = 1'b1;
    valid_n = 1'b1;
    #1;
    check("mid_rst_valid", pkt_valid, 1'b0);
    check("mid_rst_busy", busy_n, 1'b1);
    check("mid_rst_data", pkt_data, 8'h00);
    check("mid_rst_dst", pkt_dst, 4'h0);
    check("mid_rst_sop_eop", {pkt_sop, pkt_eop}, 2'b00);
    check("mid_rst_err", err_pulse, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check("post_rst_empty", pkt_valid, 1'b0);
    e0 = err_seen;
    send_packet(4'h4, 8, 136'hC3, -1, -1, 1'b0);
    exp_q.push_back(ent(8'hC3, 4'h4, 1'b1, 1'b1));
    check("post_rst_errs", err_seen - e0, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
